// File: rtl/regfile_read_port_if.sv
//==============================================================================
// regfile_read_port_if: request/response bus of the register-file read port.
// Rev 1.0
//==============================================================================
`default_nettype none

interface regfile_read_port_if #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
);
   logic             ReqValid;
   logic             ReqReady;
   logic [NREGS-1:0] ReqNum;
   logic             ReqDump;
   logic             RspValid;
   logic             RspReady;
   logic [WIDTH-1:0] RspData;
   logic [NREGS-1:0] RspNum;
   logic             RspErr;

   modport master (
      output ReqValid, ReqNum, ReqDump, RspReady,
      input  ReqReady, RspValid, RspData, RspNum, RspErr
   );

   modport slave (
      input  ReqValid, ReqNum, ReqDump, RspReady,
      output ReqReady, RspValid, RspData, RspNum, RspErr
   );
endinterface

`default_nettype wire

// File: rtl/regfile_read_port.sv
//==============================================================================
// regfile_read_port: one-hot register reads and full dumps through a 2-entry
// response buffer. Rev 1.0
//==============================================================================
`default_nettype none

module regfile_read_port #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input  wire logic                   clk,
   input  wire logic                   Reset,
   input  wire logic [NREGS*WIDTH-1:0] RegData,
   regfile_read_port_if.slave          bus,
   output logic                        Busy
);
   localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREGS - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_DUMP = 1'b1
   } state_t;

   state_t           state_q;
   logic [IDXW-1:0]  idx_q;
   logic [1:0]       count_q;

   // Slot 0 is the buffer head and directly drives the response outputs.
   logic [WIDTH-1:0] head_data_q, tail_data_q;
   logic [NREGS-1:0] head_num_q,  tail_num_q;
   logic             head_err_q,  tail_err_q;

   logic             w_pop;
   logic             w_slot;
   logic             w_req_ready;
   logic             w_accept;
   logic             w_legal;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_push;
   logic [WIDTH-1:0] w_push_data;
   logic [NREGS-1:0] w_push_num;
   logic             w_push_err;

   always_comb begin
      w_pop       = (count_q != 2'd0) && bus.RspReady;
      w_slot      = (count_q < 2'd2) || w_pop;
      w_req_ready = (state_q == S_IDLE) && w_slot;
      w_accept    = bus.ReqValid && w_req_ready;
      w_legal     = (bus.ReqNum != '0) &&
                    ((bus.ReqNum & (bus.ReqNum - 1'b1)) == '0);

      w_sel_data = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (bus.ReqNum[i]) begin
            w_sel_data = w_sel_data | RegData[i*WIDTH +: WIDTH];
         end
      end

      w_push      = 1'b0;
      w_push_data = '0;
      w_push_num  = '0;
      w_push_err  = 1'b0;
      if (state_q == S_DUMP) begin
         w_push      = w_slot;
         w_push_data = RegData[idx_q*WIDTH +: WIDTH];
         w_push_num  = {{(NREGS-1){1'b0}}, 1'b1} << idx_q;
      end else if (w_accept && !bus.ReqDump) begin
         w_push      = 1'b1;
         w_push_data = w_legal ? w_sel_data : '0;
         w_push_num  = bus.ReqNum;
         w_push_err  = !w_legal;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         count_q     <= 2'd0;
         head_data_q <= '0;
         head_num_q  <= '0;
         head_err_q  <= 1'b0;
         tail_data_q <= '0;
         tail_num_q  <= '0;
         tail_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_accept && bus.ReqDump) begin
                  state_q <= S_DUMP;
                  idx_q   <= '0;
               end
            end
            S_DUMP: begin
               if (w_slot) begin
                  if (idx_q == IDX_LAST) begin
                     state_q <= S_IDLE;
                     idx_q   <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // On the last pop the head is left untouched so outputs hold.
         case ({w_push, w_pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_data_q <= w_push_data;
                  head_num_q  <= w_push_num;
                  head_err_q  <= w_push_err;
               end else begin
                  tail_data_q <= w_push_data;
                  tail_num_q  <= w_push_num;
                  tail_err_q  <= w_push_err;
               end
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) begin
                  head_data_q <= tail_data_q;
                  head_num_q  <= tail_num_q;
                  head_err_q  <= tail_err_q;
               end
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_data_q <= w_push_data;
                  head_num_q  <= w_push_num;
                  head_err_q  <= w_push_err;
               end else begin
                  head_data_q <= tail_data_q;
                  head_num_q  <= tail_num_q;
                  head_err_q  <= tail_err_q;
                  tail_data_q <= w_push_data;
                  tail_num_q  <= w_push_num;
                  tail_err_q  <= w_push_err;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ReqReady = !Reset && w_req_ready;
   assign bus.RspValid = !Reset && (count_q != 2'd0);
   assign bus.RspData  = Reset ? '0 : head_data_q;
   assign bus.RspNum   = Reset ? '0 : head_num_q;
   assign bus.RspErr   = !Reset && head_err_q;
   assign Busy         = !Reset && ((state_q == S_DUMP) || (count_q != 2'd0));
endmodule

`default_nettype wire

// File: tb/tb_regfile_read_port.sv
//==============================================================================
// tb_regfile_read_port: directed plus randomized bench for regfile_read_port
// against a queue-based reference model. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_read_port;
   localparam int WIDTH = 8;
   localparam int NREGS = 4;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] RegData;
   logic        Busy;

   regfile_read_port_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

   regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
      .clk     (clk),
      .Reset   (Reset),
      .RegData (RegData),
      .bus     (bus),
      .Busy    (Busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of pending responses plus a dump cursor.
   typedef struct {
      logic [7:0] d;
      logic [3:0] n;
      logic       e;
   } rsp_t;

   rsp_t q[$];
   rsp_t hd;
   bit   dumping;
   int   didx;

   task automatic model_step();
      bit   pop, free, rdy;
      rsp_t e;
      if (Reset) begin
         q.delete();
         dumping = 1'b0;
         didx    = 0;
         hd      = '{8'h00, 4'h0, 1'b0};
         return;
      end
      pop  = (q.size() > 0) && bus.RspReady;
      free = (q.size() < 2) || pop;
      rdy  = !dumping && free;
      if (pop) void'(q.pop_front());
      if (dumping) begin
         if (free) begin
            e.d = RegData[didx*8 +: 8];
            e.n = 4'(1 << didx);
            e.e = 1'b0;
            q.push_back(e);
            didx++;
            if (didx == NREGS) begin
               dumping = 1'b0;
               didx    = 0;
            end
         end
      end else if (bus.ReqValid && rdy) begin
         if (bus.ReqDump) begin
            dumping = 1'b1;
            didx    = 0;
         end else begin
            e.n = bus.ReqNum;
            e.e = ($countones(bus.ReqNum) != 1);
            e.d = 8'h00;
            if (!e.e) begin
               for (int k = 0; k < NREGS; k++)
                  if (bus.ReqNum[k]) e.d = RegData[k*8 +: 8];
            end
            q.push_back(e);
         end
      end
      if (q.size() > 0) hd = q[0];
   endtask

   initial begin
      hd      = '{8'h00, 4'h0, 1'b0};
      dumping = 1'b0;
      didx    = 0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("valid", 32'(bus.RspValid), 32'(!Reset && q.size() > 0));
         check("ready", 32'(bus.ReqReady),
               32'(!Reset && !dumping && (q.size() < 2 || bus.RspReady)));
         check("busy",  32'(Busy), 32'(!Reset && (dumping || q.size() > 0)));
         check("data",  32'(bus.RspData), Reset ? 32'h0 : 32'(hd.d));
         check("num",   32'(bus.RspNum),  Reset ? 32'h0 : 32'(hd.n));
         check("err",   32'(bus.RspErr),  Reset ? 32'h0 : 32'(hd.e));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [3:0] num, input logic dmp);
      bit ok;
      ok = 1'b0;
      bus.ReqValid = 1'b1;
      bus.ReqNum   = num;
      bus.ReqDump  = dmp;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = bus.ReqReady;
         @(posedge clk);
         #1;
      end
      bus.ReqValid = 1'b0;
      bus.ReqDump  = 1'b0;
      if (!ok) check("req_timeout", 32'h0, 32'h1);
   endtask

   initial begin
      bus.ReqValid = 1'b0;
      bus.ReqNum   = 4'h0;
      bus.ReqDump  = 1'b0;
      bus.RspReady = 1'b1;
      RegData      = 32'h07060504;

      tick(); tick();
      @(negedge clk);
      check("rst_valid", 32'(bus.RspValid), 32'h0);
      check("rst_ready", 32'(bus.ReqReady), 32'h0);
      check("rst_busy",  32'(Busy), 32'h0);
      check("rst_data",  32'(bus.RspData), 32'h0);
      tick();
      Reset = 1'b0;

      // Single read, 1-cycle latency
      req(4'b0010, 1'b0);
      @(negedge clk);
      check("rd_valid", 32'(bus.RspValid), 32'h1);
      check("rd_data",  32'(bus.RspData), 32'h5);
      check("rd_num",   32'(bus.RspNum), 32'h2);
      check("rd_err",   32'(bus.RspErr), 32'h0);
      tick(); tick();

      // Fill buffer with consumer stalled
      bus.RspReady = 1'b0;
      req(4'b0001, 1'b0);
      req(4'b1000, 1'b0);
      @(negedge clk);
      check("full_ready", 32'(bus.ReqReady), 32'h0);
      check("full_head",  32'(bus.RspData), 32'h4);
      @(posedge clk); #1;
      bus.RspReady = 1'b1;
      @(negedge clk);
      check("drain0", 32'(bus.RspData), 32'h4);
      @(negedge clk);
      check("drain1", 32'(bus.RspData), 32'h7);
      check("drain1_num", 32'(bus.RspNum), 32'h8);
      tick(); tick();

      // Illegal selects
      req(4'b0000, 1'b0);
      @(negedge clk);
      check("ill0_err",  32'(bus.RspErr), 32'h1);
      check("ill0_data", 32'(bus.RspData), 32'h0);
      check("ill0_num",  32'(bus.RspNum), 32'h0);
      req(4'b0110, 1'b0);
      @(negedge clk);
      check("ill1_err",   32'(bus.RspErr), 32'h1);
      check("ill1_data",  32'(bus.RspData), 32'h0);
      check("ill1_num",   32'(bus.RspNum), 32'h6);
      check("ill1_ready", 32'(bus.ReqReady), 32'h1);
      tick(); tick(); tick();

      // Dump with free-running consumer
      req(4'b0000, 1'b1);
      @(negedge clk);
      check("dump_ready0", 32'(bus.ReqReady), 32'h0);
      check("dump_busy0",  32'(Busy), 32'h1);
      check("dump_valid0", 32'(bus.RspValid), 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("dump_data",  32'(bus.RspData), 32'(4 + k));
         check("dump_num",   32'(bus.RspNum), 32'(1 << k));
         check("dump_ready", 32'(bus.ReqReady), 32'(k == 3));
      end
      @(negedge clk);
      check("dump_busy_end", 32'(Busy), 32'h0);
      tick(); tick();

      // Dump with toggling consumer and a register update mid-dump
      req(4'b0000, 1'b1);
      RegData[31:24] = 8'h09;
      begin
         logic [11:0] pat;
         pat = 12'b110110011001;
         for (int k = 0; k < 12; k++) begin
            bus.RspReady = pat[k];
            tick();
         end
      end
      bus.RspReady = 1'b1;
      tick(); tick(); tick(); tick();
      RegData = 32'h07060504;

      // Reset in the middle of a stalled dump
      bus.RspReady = 1'b0;
      req(4'b0000, 1'b1);
      tick(); tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      bus.RspReady = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 32'(bus.RspValid), 32'h0);
      check("mid_rst_busy",  32'(Busy), 32'h0);
      req(4'b0100, 1'b0);
      @(negedge clk);
      check("post_rst_valid", 32'(bus.RspValid), 32'h1);
      check("post_rst_data",  32'(bus.RspData), 32'h6);
      tick();

      // Randomized traffic
      for (int c = 0; c < 500; c++) begin
         bus.ReqValid = ($urandom_range(1, 0) == 1);
         bus.ReqNum   = 4'($urandom());
         bus.ReqDump  = ($urandom_range(7, 0) == 0);
         bus.RspReady = ($urandom_range(2, 0) != 0);
         if ($urandom_range(3, 0) == 0) RegData = $urandom();
         Reset = ($urandom_range(63, 0) == 0);
         tick();
      end
      Reset        = 1'b0;
      bus.ReqValid = 1'b0;
      bus.ReqDump  = 1'b0;
      bus.RspReady = 1'b1;
      for (int c = 0; c < 10; c++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read-side companion to the 4-entry, 8-bit register file.
- The write side loads A into the register selected by one-hot RegNum when RegCE is high. This block is the matching reader.
- It accepts read requests over a valid/ready handshake, using the same one-hot register select, and returns register contents through a 2-entry response buffer.
- It also supports a debug dump mode that streams every register in index order.

Parameters:
WIDTH, 8, register data width
NREGS, 4, number of registers; also the width of the one-hot select

Ports:
clk  in  1  single clock, rising edge
Reset  in  1  reset; one clock; reset is synchronous and active-high
RegData  in  NREGS*WIDTH  live register contents; register i occupies bits [i*WIDTH +: WIDTH]
ReqValid  in  1  request valid
ReqReady  out  1  request can be accepted this cycle
ReqNum  in  NREGS  one-hot register select; ignored when ReqDump=1
ReqDump  in  1  request a dump of all registers
RspValid  out  1  response buffer head is valid
RspReady  in  1  consumer takes the head this cycle
RspData  out  WIDTH  head data
RspNum  out  NREGS  one-hot index of the head entry
RspErr  out  1  head came from an illegal select
Busy  out  1  high while in DUMP or while the buffer is non-empty

Behaviour:
- Reset (sampled at a clk edge while Reset=1):
  - state=IDLE, buffer count=0, dump index=0.
  - RspValid=0, RspData=0, RspNum=0, RspErr=0, Busy=0, ReqReady=0 during the reset cycle.
  - Reset asserted mid-dump or with a full buffer discards everything. No response is produced for discarded entries.
- FSM states:
  - IDLE: ReqReady = (count<2) or (count==2 and RspValid and RspReady).
  - DUMP: ReqReady=0.
- Accept: ReqValid and ReqReady at a clk edge.
  - ReqDump=0:
    - In the accept cycle, sample RegData for the selected register and push {data, ReqNum, err=0}.
    - RspValid is high the next cycle if the buffer was empty. Latency is 1 clk.
    - Illegal ReqNum (zero bits set, or more than one bit set): push {data=0, RspNum=ReqNum, err=1}. State does not change.
  - ReqDump=1:
    - Go to DUMP with index=0. Nothing is pushed in the accept cycle.
- DUMP:
  - Each cycle with a push slot free (count<2, or a pop in the same cycle), push {RegData[index], one-hot(index), err=0} and increment index.
  - When no slot is free, stall with index held.
  - After pushing index NREGS-1, return to IDLE and reset index to 0.
  - The first ReqReady=1 after a dump is the cycle after the last push.
  - Dump data is sampled at push time, so a register written mid-dump returns its new value if its index has not yet been pushed.
- Response buffer (2-entry FIFO):
  - The head drives RspData, RspNum and RspErr.
  - Pop when RspValid and RspReady.
  - A simultaneous push and pop when full is legal and count stays 2.
  - Push and pop on an empty buffer: the new entry appears the next cycle; no bypass.
  - Head outputs are stable while RspValid=1 and RspReady=0.
  - When empty, RspValid=0 and outputs hold their last values.
- Busy = (state==DUMP) or (count!=0).

Test Plan:
- Reset → all outputs 0. Preload regs with 4, 5, 6, 7 via RegData; request ReqNum=4'b0010 with RspReady=1 → next cycle RspValid=1, RspData=5, RspNum=4'b0010, RspErr=0.
- Back-to-back reads of 0001 and 1000 with RspReady=0 → count=2 and ReqReady=0; head holds 4. Raise RspReady → 4 then 7 in consecutive cycles.
- ReqNum=4'b0000, then 4'b0110 → two responses with RspErr=1 and RspData=0, RspNum echoed; FSM stays in IDLE.
- ReqDump=1 with RspReady=1 → four responses 4, 5, 6, 7 with RspNum 0001, 0010, 0100, 1000 on consecutive cycles; ReqReady=0 until after the last push; Busy falls after the last pop.
- Dump with RspReady toggling 1,0,0,1,1,… → no loss or duplication, order preserved; change reg 3 to 9 before index 3 is pushed → 9 is returned.
- Assert Reset for 1 cycle mid-dump with 2 entries buffered → RspValid=0 and Busy=0 next cycle. A following read of 0100 returns 6 with 1-cycle latency.
